// File: rtl/sd_ddr_writer_if.sv
// DDR application-side write bus between sd_ddr_writer (master) and the memory controller (slave).
interface sd_ddr_writer_if #(
  parameter int ADDR_W = 27
);
  logic              app_cmd_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [127:0]      app_wdf_data;
  logic [15:0]       app_wdf_mask;
  logic              app_cmd_rdy;
  logic              app_wdf_rdy;

  modport master (
    output app_cmd_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
           app_wdf_data, app_wdf_mask,
    input  app_cmd_rdy, app_wdf_rdy
  );

  modport slave (
    input  app_cmd_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
           app_wdf_data, app_wdf_mask,
    output app_cmd_rdy, app_wdf_rdy
  );
endinterface

// File: rtl/sd_ddr_writer.sv
// Packs 16-bit SD read words into 128-bit bursts, buffers them and writes them to the DDR app port.
// Optional macro SD_DDR_WR_DBG_EN exposes the last accepted SD word on ddr_wr_data.
module sd_ddr_writer #(
  parameter int ADDR_W     = 27,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_INC   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_calib_complete,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [23:0]       word_total,
  input  logic              sd_rd_val_en,
  input  logic [15:0]       sd_rd_val_data,
  sd_ddr_writer_if.master   app,
  output logic              wr_busy,
  output logic              wr_done,
  output logic              overflow,
  output logic [15:0]       ddr_wr_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, WAIT_CAL, RUN, FLUSH, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [23:0]       r_cnt, r_total;
  logic [127:0]      r_pack, w_pack_nxt, w_full;
  logic [2:0]        r_idx, w_idx_nxt;
  logic              r_pfull, w_pfull_nxt;
  logic              w_push;
  logic [127:0]      w_push_data;
  logic [15:0]       w_push_mask;
  logic [127:0]      r_mem_data [FIFO_DEPTH];
  logic [15:0]       r_mem_mask [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_fcnt;
  logic              r_inflight, r_cmd_en, r_wren, r_cmd_ok, r_dat_ok, r_ovf;
  logic [ADDR_W-1:0] r_addr;
  logic [127:0]      r_wdata;
  logic [15:0]       r_wmask;
  logic              w_strobe, w_drop, w_take, w_room, w_pop, w_issue;
  logic              w_cmd_hs, w_dat_hs;

  function automatic logic [127:0] place_word(input logic [127:0] d, input logic [2:0] idx,
                                              input logic [15:0] w);
    logic [127:0] r;
    r = d;
    r[{idx, 4'b0000} +: 16] = w;
    return r;
  endfunction

  // Words idx..7 are absent, so their bytes (2*idx..15) are masked.
  function automatic logic [15:0] pad_mask(input logic [2:0] idx);
    return 16'hFFFF << {idx, 1'b0};
  endfunction

  assign w_cmd_hs = r_cmd_en & app.app_cmd_rdy;
  assign w_dat_hs = r_wren & app.app_wdf_rdy;
  assign w_pop    = r_inflight & (r_cmd_ok | w_cmd_hs) & (r_dat_ok | w_dat_hs);
  assign w_issue  = !r_inflight && (r_fcnt != '0) && init_calib_complete &&
                    ((r_state == RUN) || (r_state == FLUSH));
  assign w_room   = (r_fcnt != CW'(FIFO_DEPTH)) | w_pop;
  assign w_strobe = (r_state == RUN) && sd_rd_val_en && (r_cnt != r_total);
  assign w_drop   = w_strobe && r_pfull && !w_room;
  assign w_take   = w_strobe && !w_drop;

  // A completed burst that finds the FIFO full is parked in the packer (r_pfull).
  always_comb begin
    w_push      = 1'b0;
    w_push_data = r_pack;
    w_push_mask = 16'h0000;
    w_pack_nxt  = r_pack;
    w_idx_nxt   = r_idx;
    w_pfull_nxt = r_pfull;
    w_full      = place_word(r_pack, r_idx, sd_rd_val_data);
    if (r_pfull) begin
      if (w_room) begin
        w_push      = 1'b1;
        w_pfull_nxt = 1'b0;
        w_idx_nxt   = 3'd0;
        w_pack_nxt  = '0;
        if (w_take) begin
          w_pack_nxt = place_word('0, 3'd0, sd_rd_val_data);
          w_idx_nxt  = 3'd1;
        end
      end
    end else if (w_take) begin
      if (r_idx == 3'd7) begin
        w_idx_nxt = 3'd0;
        if (w_room) begin
          w_push      = 1'b1;
          w_push_data = w_full;
          w_pack_nxt  = '0;
        end else begin
          w_pack_nxt  = w_full;
          w_pfull_nxt = 1'b1;
        end
      end else begin
        w_pack_nxt = w_full;
        w_idx_nxt  = r_idx + 3'd1;
      end
    end else if ((r_state == FLUSH) && (r_idx != 3'd0) && w_room) begin
      w_push      = 1'b1;
      w_push_mask = pad_mask(r_idx);
      w_pack_nxt  = '0;
      w_idx_nxt   = 3'd0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (wr_start) w_state_nxt = WAIT_CAL;
      WAIT_CAL: if (init_calib_complete) w_state_nxt = RUN;
      RUN:      if (r_cnt == r_total) w_state_nxt = FLUSH;
      FLUSH:    if ((r_fcnt == '0) && !r_inflight && !r_pfull && (r_idx == 3'd0))
                  w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_total    <= '0;
      r_pack     <= '0;
      r_idx      <= '0;
      r_pfull    <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fcnt     <= '0;
      r_inflight <= 1'b0;
      r_cmd_en   <= 1'b0;
      r_wren     <= 1'b0;
      r_cmd_ok   <= 1'b0;
      r_dat_ok   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pack  <= w_pack_nxt;
      r_idx   <= w_idx_nxt;
      r_pfull <= w_pfull_nxt;
      if ((r_state == IDLE) && wr_start) begin
        r_total <= word_total;
        r_cnt   <= '0;
        r_addr  <= start_addr;
        r_ovf   <= 1'b0;
      end
      if (w_strobe) r_cnt <= r_cnt + 24'd1;
      if (w_drop)   r_ovf <= 1'b1;
      if (w_push)   r_wptr <= r_wptr + PW'(1);
      if (w_pop)    r_rptr <= r_rptr + PW'(1);
      r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
      // The head entry stays in the FIFO until both strobes have been accepted.
      if (w_issue) begin
        r_inflight <= 1'b1;
        r_cmd_en   <= 1'b1;
        r_wren     <= 1'b1;
        r_cmd_ok   <= 1'b0;
        r_dat_ok   <= 1'b0;
        r_wdata    <= r_mem_data[r_rptr];
        r_wmask    <= r_mem_mask[r_rptr];
      end else if (r_inflight) begin
        if (w_cmd_hs) begin
          r_cmd_en <= 1'b0;
          r_cmd_ok <= 1'b1;
        end
        if (w_dat_hs) begin
          r_wren   <= 1'b0;
          r_dat_ok <= 1'b1;
        end
        if (w_pop) begin
          r_inflight <= 1'b0;
          r_addr     <= r_addr + ADDR_W'(ADDR_INC);
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_push_data;
      r_mem_mask[r_wptr] <= w_push_mask;
    end
  end

`ifdef SD_DDR_WR_DBG_EN
  logic [15:0] r_dbg;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  r_dbg <= '0;
    else if (w_take) r_dbg <= sd_rd_val_data;
  end
  assign ddr_wr_data = r_dbg;
`else
  assign ddr_wr_data = 16'h0000;
`endif

  assign app.app_cmd_en   = r_cmd_en;
  assign app.app_cmd      = 3'b000;
  assign app.app_addr     = r_addr;
  assign app.app_wdf_wren = r_wren;
  assign app.app_wdf_end  = r_wren;
  assign app.app_wdf_data = r_wdata;
  assign app.app_wdf_mask = r_wmask;
  assign wr_busy          = (r_state != IDLE) && (r_state != DONE);
  assign wr_done          = (r_state == DONE);
  assign overflow         = r_ovf;

endmodule

// File: tb/tb_sd_ddr_writer.sv
// Directed bench for sd_ddr_writer: table of complete transfers plus hand-written corner sequences.
module tb_sd_ddr_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        calib = 1'b1;
  logic        wr_start = 1'b0;
  logic [26:0] start_addr = '0;
  logic [23:0] word_total = '0;
  logic        sd_en = 1'b0;
  logic [15:0] sd_data = '0;
  logic        wr_busy, wr_done, overflow;
  logic [15:0] ddr_wr_data;

  sd_ddr_writer_if #(.ADDR_W(27)) app_if ();

  sd_ddr_writer #(.ADDR_W(27), .FIFO_DEPTH(4), .ADDR_INC(8)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .init_calib_complete(calib),
    .wr_start(wr_start), .start_addr(start_addr), .word_total(word_total),
    .sd_rd_val_en(sd_en), .sd_rd_val_data(sd_data), .app(app_if),
    .wr_busy(wr_busy), .wr_done(wr_done), .overflow(overflow), .ddr_wr_data(ddr_wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [26:0]  q_addr [$];
  logic [127:0] q_data [$];
  logic [15:0]  q_mask [$];

  localparam logic [127:0] D_A  = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] D_B  = 128'h000F_000E_000D_000C_000B_000A_0009_0008;
  localparam logic [127:0] D_C  = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
  localparam logic [127:0] D_10 = 128'h0000_0000_0000_0000_0000_0000_0009_0008;
  localparam logic [127:0] D_3  = 128'h0000_0000_0000_0000_0000_0002_0001_0000;
  localparam logic [127:0] D_5  = 128'h0027_0026_0025_0024_0023_0022_0021_0020;

  typedef struct {
    logic [26:0]  sa;
    logic [23:0]  tot;
    int           n;
    logic [26:0]  a0, al;
    logic [127:0] d0, dl;
    logic [15:0]  m0, ml;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are sampled on the falling edge; they complete at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (app_if.app_cmd_en && app_if.app_cmd_rdy) begin
        q_addr.push_back(app_if.app_addr);
        chk("app_cmd", {125'd0, app_if.app_cmd}, 128'd0);
      end
      if (app_if.app_wdf_wren && app_if.app_wdf_rdy) begin
        q_data.push_back(app_if.app_wdf_data);
        q_mask.push_back(app_if.app_wdf_mask);
        chk("wdf_end", {127'd0, app_if.app_wdf_end}, 128'd1);
      end
      if (wr_done) done_cnt++;
    end
  end

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_mask.delete();
    done_cnt = 0;
  endtask

  task automatic start(input logic [26:0] sa, input logic [23:0] tot);
    start_addr = sa;
    word_total = tot;
    wr_start   = 1'b1;
    tick();
    wr_start   = 1'b0;
  endtask

  task automatic feed(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      sd_en   = 1'b1;
      sd_data = 16'(base + i);
      tick();
    end
    sd_en = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int c = 0; c < 400 && done_cnt == 0; c++) tick();
    chk({nm, "_done_seen"}, {127'd0, done_cnt != 0}, 128'd1);
    tick(); tick(); tick();
  endtask

  task automatic run_xfer(input logic [26:0] sa, input logic [23:0] tot);
    clear_log();
    start(sa, tot);
    chk("busy_after_start", {127'd0, wr_busy}, 128'd1);
    tick(); tick();
    feed(0, int'(tot));
    wait_done("xfer");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{27'h100, 24'd16, 2, 27'h100, 27'h108, D_A, D_B, 16'h0000, 16'h0000};
    tbl[1] = '{27'h200, 24'd10, 2, 27'h200, 27'h208, D_A, D_10, 16'h0000, 16'hFFF0};
    tbl[2] = '{27'h7FFFFF8, 24'd16, 2, 27'h7FFFFF8, 27'h0, D_A, D_B, 16'h0000, 16'h0000};
    tbl[3] = '{27'h040, 24'd0, 0, 27'h0, 27'h0, '0, '0, 16'h0000, 16'h0000};
    tbl[4] = '{27'h010, 24'd3, 1, 27'h010, 27'h010, D_3, D_3, 16'hFFC0, 16'hFFC0};
    tbl[5] = '{27'h020, 24'd24, 3, 27'h020, 27'h030, D_A, D_C, 16'h0000, 16'h0000};
    app_if.app_cmd_rdy = 1'b1;
    app_if.app_wdf_rdy = 1'b1;

    tick(); tick();
    chk("rst_ctrl", {120'd0, app_if.app_cmd_en, app_if.app_wdf_wren, app_if.app_wdf_end,
                     wr_busy, wr_done, overflow}, 128'd0);
    chk("rst_addr", {101'd0, app_if.app_addr}, 128'd0);
    chk("rst_data", app_if.app_wdf_data, 128'd0);
    chk("rst_mask_dbg", {96'd0, app_if.app_wdf_mask, ddr_wr_data}, 128'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_xfer(tbl[v].sa, tbl[v].tot);
      chk($sformatf("v%0d_nbursts", v), 128'(q_addr.size()), 128'(tbl[v].n));
      chk($sformatf("v%0d_ndata", v), 128'(q_data.size()), 128'(tbl[v].n));
      chk($sformatf("v%0d_done_once", v), 128'(done_cnt), 128'd1);
      chk($sformatf("v%0d_ovf", v), {127'd0, overflow}, 128'd0);
      chk($sformatf("v%0d_idle", v), {127'd0, wr_busy}, 128'd0);
      if (tbl[v].n > 0 && q_addr.size() == tbl[v].n && q_data.size() == tbl[v].n) begin
        chk($sformatf("v%0d_addr0", v), 128'(q_addr[0]), 128'(tbl[v].a0));
        chk($sformatf("v%0d_addrN", v), 128'(q_addr[tbl[v].n-1]), 128'(tbl[v].al));
        chk($sformatf("v%0d_data0", v), q_data[0], tbl[v].d0);
        chk($sformatf("v%0d_dataN", v), q_data[tbl[v].n-1], tbl[v].dl);
        chk($sformatf("v%0d_mask0", v), 128'(q_mask[0]), 128'(tbl[v].m0));
        chk($sformatf("v%0d_maskN", v), 128'(q_mask[tbl[v].n-1]), 128'(tbl[v].ml));
      end
    end

    // wr_start during a transfer must not restart it.
    clear_log();
    start(27'h300, 24'd8);
    tick(); tick();
    feed(0, 4);
    start(27'h500, 24'd100);
    feed(4, 4);
    wait_done("restart");
    chk("restart_nbursts", 128'(q_addr.size()), 128'd1);
    if (q_addr.size() == 1) chk("restart_addr", 128'(q_addr[0]), 128'h300);
    if (q_data.size() == 1) chk("restart_data", q_data[0], D_A);
    chk("restart_done_once", 128'(done_cnt), 128'd1);

    // Words before calibration completes are ignored.
    clear_log();
    calib = 1'b0;
    start(27'h600, 24'd8);
    tick();
    feed(0, 8);
    chk("cal_wait_busy", {127'd0, wr_busy}, 128'd1);
    calib = 1'b1;
    tick(); tick();
    feed(16, 8);
    wait_done("cal");
    chk("cal_nbursts", 128'(q_data.size()), 128'd1);
    if (q_data.size() == 1) chk("cal_data", q_data[0], D_C);

    // Command accepted three cycles before the data beat.
    clear_log();
    app_if.app_wdf_rdy = 1'b0;
    start(27'h400, 24'd8);
    tick(); tick();
    feed(0, 8);
    for (int c = 0; c < 50 && q_addr.size() == 0; c++) tick();
    tick(); tick(); tick();
    chk("split_wren_held", {126'd0, app_if.app_wdf_wren, app_if.app_cmd_en}, 128'b10);
    app_if.app_wdf_rdy = 1'b1;
    wait_done("split");
    chk("split_ncmd", 128'(q_addr.size()), 128'd1);
    chk("split_ndata", 128'(q_data.size()), 128'd1);
    if (q_data.size() == 1) chk("split_data", q_data[0], D_A);
    chk("split_done_once", 128'(done_cnt), 128'd1);

    // Overflow: readies low, 48 words; 4 FIFO entries + 1 parked burst survive.
    clear_log();
    app_if.app_cmd_rdy = 1'b0;
    app_if.app_wdf_rdy = 1'b0;
    start(27'h0, 24'd48);
    tick(); tick();
    feed(0, 48);
    tick();
    chk("ovf_set", {127'd0, overflow}, 128'd1);
    chk("ovf_no_beats", 128'(q_data.size()), 128'd0);
    app_if.app_cmd_rdy = 1'b1;
    app_if.app_wdf_rdy = 1'b1;
    wait_done("ovf");
    chk("ovf_nbursts", 128'(q_data.size()), 128'd5);
    if (q_data.size() == 5) chk("ovf_last_data", q_data[4], D_5);
    if (q_addr.size() == 5) chk("ovf_last_addr", 128'(q_addr[4]), 128'h20);
    chk("ovf_sticky", {127'd0, overflow}, 128'd1);
    clear_log();
    start(27'h0, 24'd0);
    chk("ovf_cleared", {127'd0, overflow}, 128'd0);
    wait_done("ovf_clr");

    // Reset while a burst is waiting for ready.
    clear_log();
    app_if.app_cmd_rdy = 1'b0;
    app_if.app_wdf_rdy = 1'b0;
    start(27'h700, 24'd8);
    tick(); tick();
    feed(0, 8);
    tick(); tick();
    chk("pre_rst_cmd_en", {127'd0, app_if.app_cmd_en}, 128'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {120'd0, app_if.app_cmd_en, app_if.app_wdf_wren, app_if.app_wdf_end,
                         wr_busy, wr_done, overflow}, 128'd0);
    chk("mid_rst_addr", {101'd0, app_if.app_addr}, 128'd0);
    chk("mid_rst_data", app_if.app_wdf_data, 128'd0);
    chk("mid_rst_mask", {112'd0, app_if.app_wdf_mask}, 128'd0);
    app_if.app_cmd_rdy = 1'b1;
    app_if.app_wdf_rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    run_xfer(27'h100, 24'd16);
    chk("post_rst_nbursts", 128'(q_data.size()), 128'd2);
    if (q_data.size() == 2) chk("post_rst_data0", q_data[0], D_A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_ddr_writer.md
SD_DDR_WRITER -- requirements
Module: sd_ddr_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 27: DDR app address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of 128-bit burst entries buffered (power of 2).
REQ-003 SHALL have parameter ADDR_INC, default 8: app_addr step per burst.
REQ-004 SHALL have port sys_clk  in  1  single clock for all logic.
REQ-005 SHALL have port sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port init_calib_complete  in  1  DDR calibration done.
REQ-007 SHALL have port wr_start  in  1  one-cycle pulse that loads start_addr and word_total and begins a transfer.
REQ-008 SHALL have port start_addr  in  ADDR_W  first burst address.
REQ-009 SHALL have port word_total  in  24  number of 16-bit words in the transfer (0 = nothing to write).
REQ-010 SHALL have port sd_rd_val_en  in  1  SD read word strobe.
REQ-011 SHALL have port sd_rd_val_data  in  16  SD read word.
REQ-012 SHALL have ports app_cmd_en, app_wdf_wren, app_wdf_end  out  1 each; app_cmd  out  3; app_addr  out  ADDR_W; app_wdf_data  out  128; app_wdf_mask  out  16 (1 = byte masked).
REQ-013 SHALL have ports app_cmd_rdy, app_wdf_rdy  in  1 each: DDR controller ready.
REQ-014 SHALL have ports wr_busy, wr_done, overflow  out  1 each; ddr_wr_data  out  16.

Function
REQ-015 SHALL pack words little-endian: the k-th word of a burst (k=0..7) goes to bits [16k+15:16k].
REQ-016 SHALL push the packed word and a 16-bit mask into the FIFO on the cycle the 8th word is accepted; this gives 1-cycle packing latency.
REQ-017 SHALL accept SD words only in state RUN; strobes in other states SHALL be ignored.
REQ-018 SHALL use the states IDLE, WAIT_CAL, RUN, FLUSH, DONE.
REQ-019 IDLE -> WAIT_CAL on wr_start. WAIT_CAL -> RUN when init_calib_complete=1. RUN -> FLUSH when the accepted word count equals word_total. FLUSH -> DONE when the FIFO is empty and no burst is in flight. DONE -> IDLE after one cycle.
REQ-020 On entering FLUSH with a partial burst, the block SHALL push it zero-padded, with the mask bits of the unfilled bytes set to 1.
REQ-021 With word_total=0, the block SHALL pass RUN -> FLUSH in one cycle and issue no bursts.
REQ-022 The issue side SHALL take entries from the FIFO head and drive app_cmd=3'b000, app_cmd_en=1 and app_wdf_wren=app_wdf_end=1 together.
REQ-023 Each of the command and data strobes SHALL drop independently after its ready is seen high; the entry SHALL retire only when both have been accepted, whether in the same or in different cycles.
REQ-024 app_addr SHALL increment by ADDR_INC after each retired burst and SHALL wrap modulo 2^ADDR_W.
REQ-025 When a word arrives with the packer full and the FIFO full, the word SHALL be dropped and overflow SHALL set; overflow is sticky until the next wr_start.
REQ-026 A FIFO push and pop in the same cycle SHALL keep the occupancy unchanged.
REQ-027 wr_busy SHALL be 1 in every state except IDLE and DONE; wr_done SHALL pulse for one cycle in DONE.
REQ-028 wr_start outside IDLE SHALL be ignored.
REQ-029 If init_calib_complete drops during RUN, no new command SHALL be issued until it returns; a burst already in flight SHALL complete.

Reset
REQ-030 On sys_rst_n=0, the block SHALL asynchronously reset: state to IDLE; FIFO and packer empty; all app_* strobes 0; app_addr 0; app_wdf_data 0; app_wdf_mask 0; wr_busy, wr_done, overflow 0; ddr_wr_data 0.
REQ-031 Reset mid-transfer SHALL abandon all buffered data, and strobes SHALL drop without waiting for ready.

Configuration
REQ-032 With macro SD_DDR_WR_DBG_EN defined, ddr_wr_data SHALL register the last accepted SD word, for probing by the on-chip analyzer.
REQ-033 Without SD_DDR_WR_DBG_EN, ddr_wr_data SHALL be tied to 0 and its register SHALL be omitted.

Verification
REQ-034 Scenario: start_addr=0x100, word_total=16, words 0x0000..0x000F, readies high -> two bursts at 0x100 and 0x108; first data 0x0007_0006_..._0000; mask 0; wr_done pulses once.
REQ-035 Scenario: word_total=10 -> second burst holds words 8 and 9 in bits [31:0]; mask=16'hFFF0.
REQ-036 Scenario: app_cmd_rdy high 3 cycles before app_wdf_rdy -> exactly one command and one data beat; the entry retires once.
REQ-037 Scenario: both readies held low, 48 words sent (FIFO_DEPTH=4) -> the last 8 words are dropped and overflow=1; overflow clears on the next wr_start.
REQ-038 Scenario: start_addr=2^27-8, word_total=16 -> second burst address is 0.
REQ-039 Scenario: sys_rst_n asserted mid-burst -> all outputs are 0 in the same cycle; state is IDLE.
